// File: rtl/jtdd_sndcom.sv
`timescale 1ns/1ps
// jtdd_sndcom: sound-CPU side of the main-to-sound command channel.
// Queues each command byte written by the main CPU, holds the sound CPU IRQ
// low while bytes are queued, and stretches the sound CPU reset release.
module jtdd_sndcom #(
    parameter int DEPTH   = 2,
    parameter int RST_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cen,
    input  logic                       snd_rstb,
    input  logic                       snd_irq,
    input  logic [7:0]                 snd_latch,
    input  logic                       rd_cs,
    output logic [7:0]                 dout,
    output logic                       nirq,
    output logic                       cpu_rstn,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    RST_LD   = 8'(RST_CYC);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          nirq_q, nirq_d;
    logic          irq_q;
    logic          rd_q;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          cpu_rstn_q, cpu_rstn_d;

    logic push_edge;
    logic rd_fall;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    // Edge qualification: flush (snd_rstb low) masks both push and pop, and a
    // full FIFO only accepts a push when a pop frees a slot on the same clock.
    always_comb begin
        push_edge = snd_irq & ~irq_q;
        rd_fall   = ~rd_cs & rd_q;
        full      = (cnt_q == FULL_CNT);
        do_pop    = rd_fall & (cnt_q != '0) & snd_rstb;
        do_push   = push_edge & snd_rstb & (~full | do_pop);
        drop      = push_edge & snd_rstb & full & ~do_pop;
    end

    // Next-state for FIFO bookkeeping, overflow flag and IRQ.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        nirq_d   = (cnt_q == '0);
        if (!snd_rstb) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            last_d   = 8'hff;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                last_d   = mem_q[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Next-state for the sound CPU reset stretcher.
    always_comb begin
        rcnt_d     = rcnt_q;
        cpu_rstn_d = snd_rstb & (rcnt_q == 8'd0);
        if (!snd_rstb) begin
            rcnt_d = RST_LD;
        end else if (cen && rcnt_q != 8'd0) begin
            rcnt_d = rcnt_q - 8'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= 8'hff;
            ovf_q      <= 1'b0;
            nirq_q     <= 1'b1;
            irq_q      <= 1'b0;
            rd_q       <= 1'b0;
            rcnt_q     <= RST_LD;
            cpu_rstn_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            nirq_q     <= nirq_d;
            irq_q      <= snd_irq;
            rd_q       <= rd_cs;
            rcnt_q     <= rcnt_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    // FIFO storage; a slot being popped and pushed on the same clock hands
    // the old byte to last_q and keeps the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'hff;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= snd_latch;
        end
    end

    // Head of queue while bytes are pending, otherwise the last byte read so
    // the bus value never changes in the middle of an access.
    always_comb begin
        dout = (cnt_q != '0) ? mem_q[rd_ptr_q] : last_q;
    end

    assign nirq     = nirq_q;
    assign cpu_rstn = cpu_rstn_q;
    assign pending  = cnt_q;
    assign ovf      = ovf_q;

endmodule
